// File: rtl/conv_4u_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// conv_ctrl_pkg
// Shared definitions for the 4-lane ternary convolution sequencer: the FSM
// state encoding, kernel/tap limits, the 2-bit weight code meanings and two
// small helpers used when a layer command is accepted.
// No ports (package).
// -----------------------------------------------------------------------------
package conv_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOADW,
    S_CLR,
    S_STREAM,
    S_WAIT,
    S_EMIT,
    S_FIN
  } state_e;

  localparam int K_MAX   = 5;
  localparam int TAP_MAX = 25;

  // Meaning of each 2-bit lane code inside w_2b_4 (decoded by the datapath).
  localparam logic [1:0] CODE_NEG_W2 = 2'b00;
  localparam logic [1:0] CODE_NEG_W1 = 2'b01;
  localparam logic [1:0] CODE_ZERO   = 2'b10;
  localparam logic [1:0] CODE_POS_W  = 2'b11;

  // A kernel edge is usable when it lies in 1..K_MAX.
  function automatic logic kLegal(input logic [7:0] k);
    return (k != 8'd0) && (k <= 8'(K_MAX));
  endfunction

  // Tap count for a kernel edge, saturated so illegal edges cannot produce a
  // wrapped 8-bit product (the value is unused for them anyway).
  function automatic logic [7:0] tapsOf(input logic [7:0] k);
    logic [15:0] sq;
    sq = {8'd0, k} * {8'd0, k};
    return (sq > 16'(TAP_MAX)) ? 8'(TAP_MAX) : sq[7:0];
  endfunction

endpackage

// File: rtl/conv_4u_ctrl_if.sv
// -----------------------------------------------------------------------------
// conv_4u_ctrl_if
// Bundles every signal between the sequencer and its neighbours: the layer
// scheduler command, weight and input reader handshakes, datapath controls and
// the valid/ready result port.
//   master : the sequencer (drives busy/done/err, requests, datapath controls,
//            latched scales and the result port)
//   slave  : the surrounding system (drives start/k_size/n_win/scales,
//            reader beats, dout_32 and o_rdy)
// -----------------------------------------------------------------------------
interface conv_4u_ctrl_if #(parameter int WIN_W = 16);

  logic             start;
  logic [7:0]       k_size;
  logic [WIN_W-1:0] n_win;
  logic [7:0]       pos_w_i, neg_w1_i, neg_w2_i;
  logic             busy, done, err;
  logic             w_req, w_vld;
  logic [7:0]       w_data;
  logic             d_req, d_vld;
  logic             unit_en, w_en, z_en;
  logic [7:0]       w_2b_4;
  logic [7:0]       pos_w, neg_w1, neg_w2;
  logic [31:0]      dout_32, o_data;
  logic             o_vld, o_rdy;

  modport master (
    input  start, k_size, n_win, pos_w_i, neg_w1_i, neg_w2_i,
           w_data, w_vld, d_vld, dout_32, o_rdy,
    output busy, done, err, w_req, d_req, unit_en, w_en, z_en, w_2b_4,
           pos_w, neg_w1, neg_w2, o_data, o_vld
  );

  modport slave (
    output start, k_size, n_win, pos_w_i, neg_w1_i, neg_w2_i,
           w_data, w_vld, d_vld, dout_32, o_rdy,
    input  busy, done, err, w_req, d_req, unit_en, w_en, z_en, w_2b_4,
           pos_w, neg_w1, neg_w2, o_data, o_vld
  );

endinterface

// File: rtl/conv_4u_ctrl_beat_cnt.sv
// -----------------------------------------------------------------------------
// beat_cnt
// Loadable up-counter with a terminal compare. last_o flags the increment that
// brings the count up to term_i, so the owner can change state on that beat.
//   clk, rst_n : clock, asynchronous active-low reset
//   ld_i       : load ldVal_i (has priority over inc_i)
//   inc_i      : count one beat
//   term_i     : terminal count
//   last_o     : this increment reaches term_i
// -----------------------------------------------------------------------------
module beat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld_i,
  input  logic [W-1:0] ldVal_i,
  input  logic         inc_i,
  input  logic [W-1:0] term_i,
  output logic         last_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load wins over counting so the owner can park the counter while idle.
  always_comb begin
    cnt_d = cnt_q;
    if (ld_i) begin
      cnt_d = ldVal_i;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = !ld_i && inc_i && ((cnt_q + 1'b1) == term_i);

endmodule

// File: rtl/conv_4u_ctrl.sv
// -----------------------------------------------------------------------------
// conv_4u_ctrl
// Sequencer for one 4-lane ternary convolution unit. Accepts a layer command,
// loads taps weight beats, then per output window clears the accumulators,
// streams taps input beats, waits OUT_LAT cycles for the datapath and returns
// the 32-bit window sum through a valid/ready port.
//   clk  : clock
//   rst  : asynchronous active-low reset
//   bus  : conv_4u_ctrl_if master side (command, readers, datapath, result)
// w_en, unit_en and w_2b_4 are combinational so they line up with the reader
// beat; every other output is a register.
// -----------------------------------------------------------------------------
module conv_4u_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int OUT_LAT = 2,
  parameter int WIN_W   = 16
) (
  input  logic           clk,
  input  logic           rst,
  conv_4u_ctrl_if.master bus
);

  state_e           state_q, state_d;
  logic [7:0]       taps_q, taps_d;
  logic [WIN_W-1:0] nWin_q, nWin_d, winCnt_q, winCnt_d;
  logic             errFlag_q, errFlag_d;
  logic [7:0]       posW_q, posW_d, negW1_q, negW1_d, negW2_q, negW2_d;
  logic             busy_q, done_q, err_q, wReq_q, dReq_q, zEn_q, oVld_q;
  logic [31:0]      oData_q;
  logic             tapLd, tapInc, tapLast, latLd, latInc, latLast, capture;
  logic             wBeat;

  // One counter serves both the weight load and the input stream; it is parked
  // at zero in every other state, so CLR re-arms it between phases.
  beat_cnt #(.W(8)) u_tapCnt (
    .clk(clk), .rst_n(rst), .ld_i(tapLd), .ldVal_i(8'd0),
    .inc_i(tapInc), .term_i(taps_q), .last_o(tapLast)
  );

  beat_cnt #(.W(8)) u_latCnt (
    .clk(clk), .rst_n(rst), .ld_i(latLd), .ldVal_i(8'd0),
    .inc_i(latInc), .term_i(8'(OUT_LAT)), .last_o(latLast)
  );

  // Next-state logic. The command fields are captured once in IDLE; an illegal
  // kernel edge skips straight to FIN with the error flag set.
  always_comb begin
    state_d   = state_q;
    taps_d    = taps_q;
    nWin_d    = nWin_q;
    winCnt_d  = winCnt_q;
    errFlag_d = errFlag_q;
    posW_d    = posW_q;
    negW1_d   = negW1_q;
    negW2_d   = negW2_q;
    tapLd     = 1'b1;
    tapInc    = 1'b0;
    latLd     = 1'b1;
    latInc    = 1'b0;
    capture   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          taps_d    = tapsOf(bus.k_size);
          nWin_d    = bus.n_win;
          winCnt_d  = '0;
          errFlag_d = !kLegal(bus.k_size);
          posW_d    = bus.pos_w_i;
          negW1_d   = bus.neg_w1_i;
          negW2_d   = bus.neg_w2_i;
          state_d   = kLegal(bus.k_size) ? S_LOADW : S_FIN;
        end
      end
      S_LOADW: begin
        tapLd  = 1'b0;
        tapInc = bus.w_vld;
        if (tapLast) begin
          state_d = (nWin_q == '0) ? S_FIN : S_CLR;
        end
      end
      S_CLR: begin
        state_d = S_STREAM;
      end
      S_STREAM: begin
        tapLd  = 1'b0;
        tapInc = bus.d_vld;
        if (tapLast) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        latLd  = 1'b0;
        latInc = 1'b1;
        if (latLast) begin
          capture = 1'b1;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (bus.o_rdy) begin
          winCnt_d = winCnt_q + 1'b1;
          state_d  = (winCnt_d == nWin_q) ? S_FIN : S_CLR;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs. The registered controls are decoded from the
  // next state so they are valid for the whole cycle the FSM sits in a state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      taps_q    <= '0;
      nWin_q    <= '0;
      winCnt_q  <= '0;
      errFlag_q <= 1'b0;
      posW_q    <= '0;
      negW1_q   <= '0;
      negW2_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      wReq_q    <= 1'b0;
      dReq_q    <= 1'b0;
      zEn_q     <= 1'b0;
      oVld_q    <= 1'b0;
      oData_q   <= '0;
    end else begin
      state_q   <= state_d;
      taps_q    <= taps_d;
      nWin_q    <= nWin_d;
      winCnt_q  <= winCnt_d;
      errFlag_q <= errFlag_d;
      posW_q    <= posW_d;
      negW1_q   <= negW1_d;
      negW2_q   <= negW2_d;
      busy_q    <= (state_d != S_IDLE);
      done_q    <= (state_d == S_FIN);
      err_q     <= (state_d == S_FIN) && errFlag_d;
      wReq_q    <= (state_d == S_LOADW);
      dReq_q    <= (state_d == S_STREAM);
      zEn_q     <= (state_d == S_CLR);
      oVld_q    <= (state_d == S_EMIT);
      if (capture) begin
        oData_q <= bus.dout_32;
      end
    end
  end

  assign wBeat       = (state_q == S_LOADW) && bus.w_vld;
  assign bus.w_en    = wBeat;
  assign bus.unit_en = wBeat || ((state_q == S_STREAM) && bus.d_vld);
  assign bus.w_2b_4  = wBeat ? bus.w_data : 8'd0;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.w_req   = wReq_q;
  assign bus.d_req   = dReq_q;
  assign bus.z_en    = zEn_q;
  assign bus.o_vld   = oVld_q;
  assign bus.o_data  = oData_q;
  assign bus.pos_w   = posW_q;
  assign bus.neg_w1  = negW1_q;
  assign bus.neg_w2  = negW2_q;

endmodule
